mod_segment_switch: RTL and testbench

Sits directly downstream of the settings controller and consumes its modulation settings strobe. Decides which modulation segment (0/1) feeds the modulation memory read, switching segments immediately for infinite-repeat requests or at the loop boundary for finite requests. Counts completed loops, then stops on the final sample. Its outputs drive the modulation BRAM read address mux and the stop flag used by the intensity path.

---
 rtl/mod_segment_switch_pkg.sv | 24 ++
 rtl/mod_segment_switch_if.sv | 34 +++
 rtl/mod_segment_switch_idx_wrap_detect.sv | 18 +
 rtl/mod_segment_switch.sv | 123 ++++++++++++
 tb/tb_mod_segment_switch.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mod_segment_switch_pkg.sv
// Shared types and constants for the modulation segment switch: the infinite-repeat
// marker, the settings record produced by the settings controller, and a helper.
package params;
  localparam logic [31:0] REP_INFINITE = 32'hFFFF_FFFF;
endpackage

package settings;
  typedef struct packed {
    logic        REQ_RD_SEGMENT;
    logic [14:0] CYCLE_0;
    logic [14:0] CYCLE_1;
    logic [31:0] REP;
  } mod_settings_t;
endpackage

package mod_segment_switch_pkg;
  localparam logic [31:0] REP_INFINITE = params::REP_INFINITE;

  typedef settings::mod_settings_t mod_settings_t;

  function automatic logic is_infinite(input logic [31:0] rep);
    return rep == REP_INFINITE;
  endfunction
endpackage

// File: rtl/mod_segment_switch_if.sv
// Settings strobe, raw segment indices and switch outputs bundled as one bus.
// LOOP_CNT exists only when MOD_SEGMENT_SWITCH_STATUS_EN is defined.
interface mod_segment_switch_if #(
  parameter int IDX_W = 15
);
  import mod_segment_switch_pkg::*;

  logic                 UPDATE_SETTINGS;
  mod_settings_t        MOD_SETTINGS;
  logic [IDX_W-1:0]     IDX_0;
  logic [IDX_W-1:0]     IDX_1;
  logic                 SEGMENT;
  logic [IDX_W-1:0]     IDX;
  logic                 STOP;
`ifdef MOD_SEGMENT_SWITCH_STATUS_EN
  logic [31:0]          LOOP_CNT;
`endif

  modport master (
    output UPDATE_SETTINGS, MOD_SETTINGS, IDX_0, IDX_1,
    input  SEGMENT, IDX, STOP
`ifdef MOD_SEGMENT_SWITCH_STATUS_EN
    , input LOOP_CNT
`endif
  );

  modport slave (
    input  UPDATE_SETTINGS, MOD_SETTINGS, IDX_0, IDX_1,
    output SEGMENT, IDX, STOP
`ifdef MOD_SEGMENT_SWITCH_STATUS_EN
    , output LOOP_CNT
`endif
  );
endinterface

// File: rtl/mod_segment_switch_idx_wrap_detect.sv
// Flags the cycle in which a free-running index falls below its previous value.
module idx_wrap_detect #(
  parameter int IDX_W = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] idx,
  output logic             wrap
);
  logic [IDX_W-1:0] prev_reg;

  always_ff @(posedge CLK) begin
    if (RST) prev_reg <= '0;
    else     prev_reg <= idx;
  end

  assign wrap = (idx < prev_reg);
endmodule

// File: rtl/mod_segment_switch.sv
// Chooses the modulation segment feeding the memory read and stops finite sequences.
// Define MOD_SEGMENT_SWITCH_STATUS_EN to expose the loop counter as LOOP_CNT.
module mod_segment_switch
  import mod_segment_switch_pkg::*;
#(
  parameter int IDX_W = 15
) (
  input  logic                CLK,
  input  logic                RST,
  mod_segment_switch_if.slave bus
);
  localparam logic [1:0] ST_INFINITE   = 2'd0;
  localparam logic [1:0] ST_WAIT_START = 2'd1;
  localparam logic [1:0] ST_FINITE     = 2'd2;
  localparam logic [1:0] ST_STOPPED    = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic             segment_reg, segment_next;
  logic             stop_reg, stop_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [31:0]      loop_cnt_reg, loop_cnt_next;
  logic             switch_pend_reg, switch_pend_next;
  logic             req_seg_reg;
  logic [31:0]      req_rep_reg;
  logic [IDX_W-1:0] cycle_q_reg [2];
  logic [IDX_W-1:0] raw_idx [2];
  logic [1:0]       wrap;

  assign raw_idx[0] = bus.IDX_0;
  assign raw_idx[1] = bus.IDX_1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wrap
      idx_wrap_detect #(.IDX_W(IDX_W)) u_wrap (
        .CLK  (CLK),
        .RST  (RST),
        .idx  (raw_idx[gi]),
        .wrap (wrap[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    segment_next     = segment_reg;
    stop_next        = stop_reg;
    loop_cnt_next    = loop_cnt_reg;
    switch_pend_next = 1'b0;

    // A new request always takes priority over a wrap seen in the same cycle.
    if (bus.UPDATE_SETTINGS) begin
      if (is_infinite(bus.MOD_SETTINGS.REP)) begin
        state_next       = ST_INFINITE;
        stop_next        = 1'b0;
        switch_pend_next = 1'b1;
      end else begin
        state_next = ST_WAIT_START;
      end
    end else begin
      if (switch_pend_reg) segment_next = req_seg_reg;
      case (state_reg)
        ST_WAIT_START: begin
          if (wrap[segment_reg]) begin
            segment_next  = req_seg_reg;
            loop_cnt_next = 32'd0;
            stop_next     = 1'b0;
            state_next    = ST_FINITE;
          end
        end
        ST_FINITE: begin
          if (wrap[segment_reg]) begin
            if (loop_cnt_reg == req_rep_reg) begin
              state_next = ST_STOPPED;
              stop_next  = 1'b1;
            end else begin
              loop_cnt_next = loop_cnt_reg + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end

    // Parking on the last sample keeps the intensity path on a stable value.
    if (state_next == ST_STOPPED) idx_next = cycle_q_reg[segment_reg];
    else                          idx_next = raw_idx[segment_reg];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= ST_INFINITE;
      segment_reg     <= 1'b0;
      stop_reg        <= 1'b0;
      idx_reg         <= '0;
      loop_cnt_reg    <= 32'd0;
      switch_pend_reg <= 1'b0;
      req_seg_reg     <= 1'b0;
      req_rep_reg     <= 32'd0;
      cycle_q_reg[0]  <= '0;
      cycle_q_reg[1]  <= '0;
    end else begin
      state_reg       <= state_next;
      segment_reg     <= segment_next;
      stop_reg        <= stop_next;
      idx_reg         <= idx_next;
      loop_cnt_reg    <= loop_cnt_next;
      switch_pend_reg <= switch_pend_next;
      if (bus.UPDATE_SETTINGS) begin
        req_seg_reg    <= bus.MOD_SETTINGS.REQ_RD_SEGMENT;
        req_rep_reg    <= bus.MOD_SETTINGS.REP;
        cycle_q_reg[0] <= IDX_W'(bus.MOD_SETTINGS.CYCLE_0);
        cycle_q_reg[1] <= IDX_W'(bus.MOD_SETTINGS.CYCLE_1);
      end
    end
  end

  assign bus.SEGMENT = segment_reg;
  assign bus.IDX     = idx_reg;
  assign bus.STOP    = stop_reg;
`ifdef MOD_SEGMENT_SWITCH_STATUS_EN
  assign bus.LOOP_CNT = loop_cnt_reg;
`endif
endmodule

// File: tb/tb_mod_segment_switch.sv
// Directed bench for mod_segment_switch: free-running segment counters (periods 6 and 4)
// with hand-derived expectations for switching, looping, stopping and reset.
module tb_mod_segment_switch;
  import mod_segment_switch_pkg::*;

  localparam int         IDX_W = 15;
  localparam logic [14:0] C0   = 15'd5;
  localparam logic [14:0] C1   = 15'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [IDX_W-1:0] s_idx0, s_idx1;

  always #5 clk = ~clk;

  mod_segment_switch_if #(.IDX_W(IDX_W)) bus ();

  mod_segment_switch #(.IDX_W(IDX_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("check %s: got=%0d", tag, got);
    end
  endtask

  // Advance one clock; s_idx* capture what the DUT sampled at that edge.
  task automatic tick();
    @(posedge clk);
    s_idx0 = bus.IDX_0;
    s_idx1 = bus.IDX_1;
    #1;
    bus.UPDATE_SETTINGS = 1'b0;
    if (run) begin
      bus.IDX_0 = (bus.IDX_0 == C0) ? 15'd0 : bus.IDX_0 + 15'd1;
      bus.IDX_1 = (bus.IDX_1 == C1) ? 15'd0 : bus.IDX_1 + 15'd1;
    end
  endtask

  task automatic send(input logic seg, input logic [31:0] rep);
    bus.MOD_SETTINGS.REQ_RD_SEGMENT = seg;
    bus.MOD_SETTINGS.CYCLE_0        = C0;
    bus.MOD_SETTINGS.CYCLE_1        = C1;
    bus.MOD_SETTINGS.REP            = rep;
    bus.UPDATE_SETTINGS             = 1'b1;
    tick();
  endtask

  // Tick until the DUT has sampled a wrap (index back to 0) on the given segment.
  task automatic wait_wrap(input logic seg, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (((seg ? s_idx1 : s_idx0) != 15'd0) && (n < 20));
    if ((seg ? s_idx1 : s_idx0) != 15'd0) begin
      checks++;
      errors++;
      $display("FAIL %s: no wrap within 20 cycles", tag);
    end
  endtask

  initial begin
    bus.UPDATE_SETTINGS = 1'b0;
    bus.MOD_SETTINGS    = '0;
    bus.IDX_0           = 15'd0;
    bus.IDX_1           = 15'd0;

    repeat (3) tick();
    check("rst_segment", 32'(bus.SEGMENT), 32'd0);
    check("rst_idx", 32'(bus.IDX), 32'd0);
    check("rst_stop", 32'(bus.STOP), 32'd0);
`ifdef MOD_SEGMENT_SWITCH_STATUS_EN
    check("rst_loop_cnt", bus.LOOP_CNT, 32'd0);
`endif
    rst = 1'b0;
    bus.IDX_1 = 15'd2;
    run = 1'b1;

    // Infinite request for segment 1: switch two edges after the strobe.
    send(1'b1, REP_INFINITE);
    check("inf_seg_pending", 32'(bus.SEGMENT), 32'd0);
    tick();
    check("inf_seg_switch", 32'(bus.SEGMENT), 32'd1);
    check("inf_stop", 32'(bus.STOP), 32'd0);
    tick();
    check("inf_idx_tracks1", 32'(bus.IDX), 32'(s_idx1));
    tick();
    check("inf_idx_tracks1b", 32'(bus.IDX), 32'(s_idx1));

    // Back to segment 0, then finite request for segment 1 with two loops.
    send(1'b0, REP_INFINITE);
    tick();
    check("inf_back_seg0", 32'(bus.SEGMENT), 32'd0);
    tick();
    check("inf_idx_tracks0", 32'(bus.IDX), 32'(s_idx0));
    send(1'b1, 32'd1);
    check("fin_wait_seg0", 32'(bus.SEGMENT), 32'd0);
    wait_wrap(1'b0, "fin_wrap0");
    check("fin_switch_seg1", 32'(bus.SEGMENT), 32'd1);
    check("fin_stop_low", 32'(bus.STOP), 32'd0);
`ifdef MOD_SEGMENT_SWITCH_STATUS_EN
    check("fin_loop_cnt0", bus.LOOP_CNT, 32'd0);
`endif
    wait_wrap(1'b1, "fin_wrap1a");
    check("fin_loop1_stop", 32'(bus.STOP), 32'd0);
    check("fin_loop1_idx", 32'(bus.IDX), 32'd0);
    wait_wrap(1'b1, "fin_wrap1b");
    check("fin_stop_high", 32'(bus.STOP), 32'd1);
    check("fin_idx_held", 32'(bus.IDX), 32'd3);
    tick();
    tick();
    check("fin_idx_hold2", 32'(bus.IDX), 32'd3);
    check("fin_stop_hold", 32'(bus.STOP), 32'd1);
    check("fin_seg_hold", 32'(bus.SEGMENT), 32'd1);

    // Infinite request while stopped.
    send(1'b0, REP_INFINITE);
    check("stopped_inf_stop", 32'(bus.STOP), 32'd0);
    tick();
    check("stopped_inf_seg", 32'(bus.SEGMENT), 32'd0);
    tick();
    check("stopped_inf_idx", 32'(bus.IDX), 32'(s_idx0));

    // Finite REP=0 on the already active segment: one full loop, then stop.
    send(1'b0, 32'd0);
    wait_wrap(1'b0, "rep0_wrap_a");
    check("rep0_seg", 32'(bus.SEGMENT), 32'd0);
    check("rep0_stop_low", 32'(bus.STOP), 32'd0);
    tick();
    check("rep0_idx_play", 32'(bus.IDX), 32'd1);
    wait_wrap(1'b0, "rep0_wrap_b");
    check("rep0_stop_high", 32'(bus.STOP), 32'd1);
    check("rep0_idx_held", 32'(bus.IDX), 32'd5);

    // Update coinciding with a wrap in WAIT_START: that wrap is ignored.
    send(1'b0, REP_INFINITE);
    tick();
    send(1'b1, 32'd5);
    for (int n = 0; n < 20 && bus.IDX_0 != 15'd0; n++) tick();
    send(1'b1, 32'd5);
    check("coinc_wrap_seen", 32'(s_idx0), 32'd0);
    check("coinc_no_switch", 32'(bus.SEGMENT), 32'd0);
    wait_wrap(1'b0, "coinc_next_wrap");
    check("coinc_switch", 32'(bus.SEGMENT), 32'd1);

    // Reset in the middle of the finite sequence.
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_segment", 32'(bus.SEGMENT), 32'd0);
    check("midrst_idx", 32'(bus.IDX), 32'd0);
    check("midrst_stop", 32'(bus.STOP), 32'd0);
`ifdef MOD_SEGMENT_SWITCH_STATUS_EN
    check("midrst_loop_cnt", bus.LOOP_CNT, 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("postrst_idx", 32'(bus.IDX), 32'(s_idx0));
    wait_wrap(1'b0, "postrst_wrap_a");
    wait_wrap(1'b0, "postrst_wrap_b");
    check("postrst_seg", 32'(bus.SEGMENT), 32'd0);
    check("postrst_stop", 32'(bus.STOP), 32'd0);

`ifdef MOD_SEGMENT_SWITCH_STATUS_EN
    // Loop counter walk with REP=2.
    send(1'b1, 32'd2);
    wait_wrap(1'b0, "cnt_wrap0");
    check("cnt_step0", bus.LOOP_CNT, 32'd0);
    wait_wrap(1'b1, "cnt_wrap1a");
    check("cnt_step1", bus.LOOP_CNT, 32'd1);
    wait_wrap(1'b1, "cnt_wrap1b");
    check("cnt_step2", bus.LOOP_CNT, 32'd2);
    check("cnt_not_stopped", 32'(bus.STOP), 32'd0);
    wait_wrap(1'b1, "cnt_wrap1c");
    check("cnt_stop", 32'(bus.STOP), 32'd1);
    check("cnt_final", bus.LOOP_CNT, 32'd2);
    tick();
    check("cnt_hold", bus.LOOP_CNT, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
